// File: rtl/leb128_fetch.sv
// Immediate-operand fetch: reads a byte window from genrom and decodes one
// ULEB128/SLEB128 immediate into a 64-bit value plus its encoded length.
module leb128_fetch #(
    parameter int MEM_DEPTH = 4,
    parameter int MEM_EXTRA = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [MEM_DEPTH:0]          addr,
    input  logic                        is_signed,
    input  logic                        is64,
    output logic [MEM_DEPTH:0]          mem_addr,
    output logic [MEM_EXTRA-1:0]        mem_extra,
    input  logic [8*(2**MEM_EXTRA)-1:0] mem_data,
    input  logic                        mem_error,
    output logic                        busy,
    output logic                        done,
    output logic [63:0]                 value,
    output logic [3:0]                  length,
    output logic [1:0]                  error
);

    localparam int DW = 8 * (2 ** MEM_EXTRA);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, DECODE, DONE} state_t;

    state_t             state, next_state;
    logic [MEM_DEPTH:0] req_addr;
    logic               req_signed;
    logic               req_is64;
    logic [DW-1:0]      window;
    logic [63:0]        acc;
    logic [3:0]         count;

    logic [7:0]  cur_byte;
    logic [3:0]  new_count;
    logic [6:0]  shift_amt;
    logic [6:0]  ext_shift;
    logic [63:0] new_acc;
    logic [63:0] ext_mask;
    logic [63:0] ext_acc;
    logic [63:0] final_value;
    logic        last_byte;
    logic        too_long;

    // Per-byte decode step: accumulate 7 payload bits and work out the
    // sign-extended / width-adjusted result in case this byte is the last.
    always_comb begin
        cur_byte  = window[DW-1 -: 8];
        new_count = count + 4'd1;
        shift_amt = 7'(count) * 7'd7;
        ext_shift = 7'(new_count) * 7'd7;
        new_acc   = acc | ({57'b0, cur_byte[6:0]} << shift_amt);
        ext_mask  = (ext_shift >= 7'd64) ? 64'b0 : ({64{1'b1}} << ext_shift);
        ext_acc   = (req_signed && cur_byte[6]) ? (new_acc | ext_mask) : new_acc;
        if (req_is64)
            final_value = ext_acc;
        else if (req_signed)
            final_value = {{32{ext_acc[31]}}, ext_acc[31:0]};
        else
            final_value = {32'b0, ext_acc[31:0]};
        last_byte = ~cur_byte[7];
        too_long  = cur_byte[7] && (new_count == (req_is64 ? 4'd10 : 4'd5));
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        mem_addr   = '0;
        mem_extra  = '0;
        case (state)
            IDLE:   if (start) next_state = FETCH;
            FETCH: begin
                mem_addr   = req_addr;
                mem_extra  = req_is64 ? MEM_EXTRA'(9) : MEM_EXTRA'(4);
                next_state = LOAD;
            end
            LOAD:   next_state = mem_error ? DONE : DECODE;
            DECODE: if (last_byte || too_long) next_state = DONE;
            DONE:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Result registers only change when entering DONE, so they stay stable
    // between done pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_addr   <= '0;
            req_signed <= 1'b0;
            req_is64   <= 1'b0;
            window     <= '0;
            acc        <= '0;
            count      <= '0;
            value      <= '0;
            length     <= '0;
            error      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        req_addr   <= addr;
                        req_signed <= is_signed;
                        req_is64   <= is64;
                    end
                end
                LOAD: begin
                    window <= mem_data;
                    acc    <= '0;
                    count  <= '0;
                    if (mem_error) begin
                        value  <= '0;
                        length <= '0;
                        error  <= 2'd1;
                    end
                end
                DECODE: begin
                    window <= window << 8;
                    acc    <= new_acc;
                    count  <= new_count;
                    if (last_byte) begin
                        value  <= final_value;
                        length <= new_count;
                        error  <= 2'd0;
                    end else if (too_long) begin
                        value  <= new_acc;
                        length <= new_count;
                        error  <= 2'd2;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_leb128_fetch.sv
// Self-checking bench for leb128_fetch: registered genrom model, vector table
// with a scoreboard queue, plus hand-written fault/reset/back-to-back sequences.
module tb_leb128_fetch;

    localparam int MEM_DEPTH = 4;
    localparam int MEM_EXTRA = 4;
    localparam int DW        = 8 * (2 ** MEM_EXTRA);
    localparam int ROM_SIZE  = 2 ** (MEM_DEPTH + 1);

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic [MEM_DEPTH:0]   addr;
    logic                 is_signed;
    logic                 is64;
    logic [MEM_DEPTH:0]   mem_addr;
    logic [MEM_EXTRA-1:0] mem_extra;
    logic [DW-1:0]        mem_data;
    logic                 mem_error;
    logic                 busy;
    logic                 done;
    logic [63:0]          value;
    logic [3:0]           length;
    logic [1:0]           error;

    leb128_fetch #(.MEM_DEPTH(MEM_DEPTH), .MEM_EXTRA(MEM_EXTRA)) dut (
        .clk(clk), .reset(reset), .start(start), .addr(addr),
        .is_signed(is_signed), .is64(is64), .mem_addr(mem_addr),
        .mem_extra(mem_extra), .mem_data(mem_data), .mem_error(mem_error),
        .busy(busy), .done(done), .value(value), .length(length), .error(error)
    );

    always #5 clk = ~clk;

    logic [7:0] rom [ROM_SIZE];
    int         rom_upper_bound;
    int         cycle_cnt = 0;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // genrom model: registered window read, top byte is the byte at mem_addr
    always @(posedge clk) begin
        logic [DW-1:0] w;
        int idx;
        w = '0;
        for (int i = 0; i < DW / 8; i++) begin
            idx = int'(mem_addr) + i;
            w[DW-1-8*i -: 8] = (idx < ROM_SIZE) ? rom[idx] : 8'h00;
        end
        mem_data  <= w;
        mem_error <= (int'(mem_addr) + int'(mem_extra)) > rom_upper_bound;
    end

    typedef struct {
        logic [MEM_DEPTH:0] a;
        logic               sg;
        logic               w64;
        logic [63:0]        v;
        logic [3:0]         len;
        logic [1:0]         err;
        int                 lat;
    } vec_t;

    vec_t vecs [8];
    vec_t exp_q [$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic checkOutput(input int start_cycle);
        vec_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard: got done with empty queue expected none");
            return;
        end
        e = exp_q.pop_front();
        check("value", value, e.v);
        check("length", 64'(length), 64'(e.len));
        check("error", 64'(error), 64'(e.err));
        check("latency", 64'(cycle_cnt - start_cycle), 64'(e.lat));
    endtask

    // Drives one request, pushes its expectation, then waits (bounded) for done.
    task automatic applyStimulus(input vec_t v);
        int sc;
        bit seen;
        @(negedge clk);
        start     = 1'b1;
        addr      = v.a;
        is_signed = v.sg;
        is64      = v.w64;
        sc        = cycle_cnt;
        exp_q.push_back(v);
        @(negedge clk);
        start = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (done) begin
                checkOutput(sc);
                seen = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("[TB] FAIL timeout: got no done expected done within 20 cycles");
            void'(exp_q.pop_front());
        end
    endtask

    initial begin
        vec_t ev;
        int   sc;
        bit   saw_done;

        for (int i = 0; i < ROM_SIZE; i++) rom[i] = 8'h00;
        rom[0] = 8'h05;
        rom[1] = 8'hE5; rom[2] = 8'h8E; rom[3] = 8'h26;
        rom[4] = 8'h7F;
        rom[5] = 8'hC0; rom[6] = 8'hBB; rom[7] = 8'h78;
        for (int i = 8; i < 14; i++) rom[i] = 8'h80;
        for (int i = 14; i < 25; i++) rom[i] = 8'hFF;
        rom_upper_bound = ROM_SIZE - 1;

        vecs[0] = '{5'd0,  1'b0, 1'b0, 64'd5,                  4'd1,  2'd0, 4};
        vecs[1] = '{5'd1,  1'b0, 1'b0, 64'h98765,              4'd3,  2'd0, 6};
        vecs[2] = '{5'd4,  1'b1, 1'b1, 64'hFFFFFFFFFFFFFFFF,   4'd1,  2'd0, 4};
        vecs[3] = '{5'd5,  1'b1, 1'b0, 64'hFFFFFFFFFFFE1DC0,   4'd3,  2'd0, 6};
        vecs[4] = '{5'd8,  1'b0, 1'b0, 64'd0,                  4'd5,  2'd2, 8};
        vecs[5] = '{5'd14, 1'b0, 1'b1, 64'hFFFFFFFFFFFFFFFF,   4'd10, 2'd2, 13};
        vecs[6] = '{5'd4,  1'b0, 1'b0, 64'h7F,                 4'd1,  2'd0, 4};
        vecs[7] = '{5'd1,  1'b1, 1'b1, 64'h98765,              4'd3,  2'd0, 6};

        reset = 1'b1; start = 1'b0; addr = '0; is_signed = 1'b0; is64 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_value", value, 64'd0);
        check("reset_mem_addr", 64'(mem_addr), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

        // start coinciding with done is dropped; block is idle the next cycle
        ev = vecs[0];
        @(negedge clk);
        start = 1'b1; addr = ev.a; is_signed = ev.sg; is64 = ev.w64;
        sc = cycle_cnt;
        exp_q.push_back(ev);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && !done; i++) @(negedge clk);
        checkOutput(sc);
        start = 1'b1; addr = 5'd4;
        @(negedge clk);
        start = 1'b0;
        check("start_during_done_busy", 64'(busy), 64'd0);
        check("start_during_done_hold", value, 64'd5);

        // genrom bounds fault
        rom_upper_bound = 2;
        applyStimulus('{5'd4, 1'b0, 1'b0, 64'd0, 4'd0, 2'd1, 3});
        rom_upper_bound = ROM_SIZE - 1;

        // reset in DECODE drops the request
        @(negedge clk);
        start = 1'b1; addr = 5'd14; is_signed = 1'b0; is64 = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_in_decode", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("reset_mid_busy", 64'(busy), 64'd0);
        check("reset_mid_value", value, 64'd0);
        saw_done = 1'b0;
        repeat (15) begin
            if (done) saw_done = 1'b1;
            @(negedge clk);
        end
        check("no_done_after_reset", 64'(saw_done), 64'd0);

        applyStimulus(vecs[3]);
        applyStimulus(vecs[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
